mux_skid_pipe: RTL



---
 rtl/mux_skid_pipe_pkg.sv | 26 ++
 rtl/mux_skid_pipe_skid.sv | 83 ++++++++
 rtl/mux_skid_pipe.sv | 97 +++++++++
 3 files changed

// File: rtl/mux_skid_pipe_pkg.sv
// mux_pkg: shared types, defaults and helpers for the mux_skid_pipe datapath
// stage and its skid register.
package mux_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_N     = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Gray-to-binary conversion. Callers zero-extend a narrower code to 32 bits
  // and truncate the result back; leading zeros leave the low bits unchanged,
  // so this works for any select width up to 32.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/mux_skid_pipe_skid.sv
// skid_reg2: two-entry registered skid stage with valid/ready on both sides.
// The main register feeds the output. The skid register catches the one word
// accepted while the output is stalled. in_ready and out_valid are flops so
// that no combinational path crosses the stage.
module skid_reg2
  import mux_pkg::*;
#(
  parameter int PW = 18
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [PW-1:0] data_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [PW-1:0] data_o,
  output logic          valid_o,
  input  logic          ready_i
);

  skid_state_t   state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          accept;
  logic          xfer;

  assign accept  = valid_i & in_ready_q;
  assign xfer    = out_valid_q & ready_i;
  assign ready_o = in_ready_q;
  assign valid_o = out_valid_q;
  assign data_o  = main_q;

  // Next-state and register-load decisions for the EMPTY/ONE/FULL occupancy machine
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = data_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          main_d = data_i;
        end else if (accept) begin
          skid_d  = data_i;
          state_d = FULL;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, data registers and the registered handshake flags derived from the next state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

endmodule

// File: rtl/mux_skid_pipe.sv
// mux_skid_pipe: N:1 operand mux followed by a registered two-entry skid stage.
// The select is optionally Gray-coded (GRAY_SEL) to keep the legacy control
// encoding. Out-of-range selects forward zero data tagged with the raw index.
// Define MUX_SEL_CHECK_EN to build the sticky out-of-range flag sel_err.
// Without it, sel_err is tied low.
module mux_skid_pipe
  import mux_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int N        = DEF_N,
  parameter  int GRAY_SEL = 1,
  localparam int SW       = $clog2(N)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [N-1:0][WIDTH-1:0] d,
  input  logic [SW-1:0]         select,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      dout,
  output logic [SW-1:0]         dout_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  logic [SW-1:0]       idx;
  logic [WIDTH-1:0]    mux_data;
  logic [SW+WIDTH-1:0] payload_in;
  logic [SW+WIDTH-1:0] payload_out;

  // Turn the incoming select into a binary channel index
  always_comb begin
    idx = select;
    if (GRAY_SEL != 0) begin
      idx = SW'(gray2bin(32'(select)));
    end
  end

  // Channel mux; an index with no matching channel leaves the data at zero
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == SW'(i)) begin
        mux_data = d[i];
      end
    end
  end

  assign payload_in = {idx, mux_data};

  skid_reg2 #(
    .PW(SW + WIDTH)
  ) u_skid (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .data_i (payload_in),
    .valid_i(in_valid),
    .ready_o(in_ready),
    .data_o (payload_out),
    .valid_o(out_valid),
    .ready_i(out_ready)
  );

  assign dout     = payload_out[WIDTH-1:0];
  assign dout_sel = payload_out[SW+WIDTH-1:WIDTH];

`ifdef MUX_SEL_CHECK_EN
  logic in_range;
  logic sel_err_q, sel_err_d;

  // Decide whether the current index names a real channel
  always_comb begin
    in_range = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (idx == SW'(i)) begin
        in_range = 1'b1;
      end
    end
    sel_err_d = sel_err_q | (in_valid & in_ready & ~in_range);
  end

  // Sticky flag: once an out-of-range select is accepted, only reset clears it
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule
